// File: rtl/coffee_pkg.sv
// Shared definitions for the coffee vending datapath.
// Contents:
//   drink_t    drink selection encoding (matches the 3-bit coffee_type input)
//   state_t    dispense controller states
//   BREW_S_*   brew duration per drink, in seconds
//   PRICE_*    drink prices in coins, also used by the coin/price subtractor
//   brew_secs  maps a drink to its brew duration
package coffee_pkg;

    typedef enum logic [1:0] {
        ESPRESSO    = 2'd0,
        COFFEE_MILK = 2'd1,
        CAPUCCINO   = 2'd2,
        MOCACCINO   = 2'd3
    } drink_t;

    typedef enum logic [1:0] {
        IDLE,
        BREW,
        CHANGE,
        DONE
    } state_t;

    localparam logic [4:0] BREW_S_ESPRESSO    = 5'd10;
    localparam logic [4:0] BREW_S_COFFEE_MILK = 5'd15;
    localparam logic [4:0] BREW_S_CAPUCCINO   = 5'd20;
    localparam logic [4:0] BREW_S_MOCACCINO   = 5'd25;

    localparam logic [3:0] PRICE_ESPRESSO    = 4'd3;
    localparam logic [3:0] PRICE_COFFEE_MILK = 4'd4;
    localparam logic [3:0] PRICE_CAPUCCINO   = 4'd5;
    localparam logic [3:0] PRICE_MOCACCINO   = 4'd7;

    function automatic logic [4:0] brew_secs(input drink_t d);
        logic [4:0] s;
        case (d)
            ESPRESSO:    s = BREW_S_ESPRESSO;
            COFFEE_MILK: s = BREW_S_COFFEE_MILK;
            CAPUCCINO:   s = BREW_S_CAPUCCINO;
            default:     s = BREW_S_MOCACCINO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/brew_dispense_ctrl_if.sv
// Coin hopper handshake between the dispense controller and the hopper.
// Signals:
//   coin_valid  controller -> hopper  request to eject one coin
//   coin_ready  hopper -> controller  hopper can take one coin this cycle
// A coin is paid on every cycle where both are high.
interface brew_dispense_ctrl_if;

    logic coin_valid;
    logic coin_ready;

    modport master (output coin_valid, input coin_ready);
    modport slave  (input coin_valid, output coin_ready);

endinterface

// File: rtl/brew_dispense_ctrl_sec_tick_gen.sv
// One-second tick prescaler.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   clr    in  synchronous clear of the prescaler
//   en     in  count enable
//   tick   out one-cycle pulse on the cycle the prescaler wraps
// Parameter TICK_DIV: clk cycles per tick (>= 1).
module sec_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/brew_dispense_ctrl.sv
// Brew dispense controller: accepts a paid brew request, times the brew in
// seconds, pays change to the coin hopper one coin per handshake, then
// signals completion. Also pulses coins_clr so the upstream accumulator
// clears its total.
// Ports:
//   clk, rst_n     system clock, synchronous active-low reset
//   brew_req       one-cycle brew button pulse
//   coffee_type    drink select (0..3 valid)
//   enable_timer   enough coins inserted for coffee_type
//   change         coins to return after the brew
//   coin           hopper handshake (master side: coin_valid out, coin_ready in)
//   coins_clr      one-cycle pulse on the first brew cycle
//   brewing        high while the brew timer runs
//   busy           high outside IDLE
//   sec_left       brew seconds remaining (0 outside BREW)
//   done           one-cycle pulse when the sale completes
// Optional feature, macro BREW_ABORT_EN: adds abort_req and total_coins;
// an abort during BREW refunds the full latched total_coins instead of change.
module brew_dispense_ctrl
    import coffee_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        brew_req,
    input  logic [2:0]                  coffee_type,
    input  logic                        enable_timer,
    input  logic [3:0]                  change,
`ifdef BREW_ABORT_EN
    input  logic                        abort_req,
    input  logic [3:0]                  total_coins,
`endif
    brew_dispense_ctrl_if.master        coin,
    output logic                        coins_clr,
    output logic                        brewing,
    output logic                        busy,
    output logic [4:0]                  sec_left,
    output logic                        done
);

    state_t     state_q, state_d;
    drink_t     type_q;
    logic [3:0] remain_q;
    logic [4:0] elapsed_q;
    logic       clr_q;
    logic       tick;
    logic       accept;
    logic       in_brew;
    logic       final_tick;
    logic       abort_hit;
    logic       handshake;
    logic [4:0] brew_len;

    assign accept    = (state_q == IDLE) && brew_req && enable_timer && (coffee_type <= 3'd3);
    assign in_brew   = (state_q == BREW);
    assign brew_len  = brew_secs(type_q);
    // Elapsed seconds are counted up; remaining time is derived from the
    // latched drink so the drink type itself is what stays latched.
    assign final_tick = tick && (elapsed_q == brew_len - 5'd1);
    assign handshake = coin.coin_valid && coin.coin_ready;
    assign coins_clr = clr_q;

`ifdef BREW_ABORT_EN
    logic [3:0] total_q;
    assign abort_hit = in_brew && abort_req;
`else
    assign abort_hit = 1'b0;
`endif

    sec_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!in_brew),
        .en   (in_brew),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        busy            = 1'b1;
        brewing         = 1'b0;
        done            = 1'b0;
        sec_left        = '0;
        coin.coin_valid = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_d = BREW;
            end
            BREW: begin
                brewing  = 1'b1;
                sec_left = brew_len - elapsed_q;
`ifdef BREW_ABORT_EN
                // Abort takes priority over a coincident final tick.
                if (abort_hit) begin
                    state_d = (total_q != 4'd0) ? CHANGE : DONE;
                end else
`endif
                if (final_tick) begin
                    state_d = (remain_q != 4'd0) ? CHANGE : DONE;
                end
            end
            CHANGE: begin
                coin.coin_valid = (remain_q != 4'd0);
                if (handshake && remain_q == 4'd1) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            type_q    <= ESPRESSO;
            remain_q  <= '0;
            elapsed_q <= '0;
            clr_q     <= 1'b0;
`ifdef BREW_ABORT_EN
            total_q   <= '0;
`endif
        end else begin
            clr_q <= accept;
            if (accept) begin
                type_q    <= drink_t'(coffee_type[1:0]);
                remain_q  <= change;
                elapsed_q <= '0;
`ifdef BREW_ABORT_EN
                total_q   <= total_coins;
`endif
            end else if (in_brew) begin
`ifdef BREW_ABORT_EN
                if (abort_hit) begin
                    remain_q <= total_q;
                end else
`endif
                if (tick) begin
                    elapsed_q <= elapsed_q + 5'd1;
                end
            end else if (handshake) begin
                remain_q <= remain_q - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_brew_dispense_ctrl.sv
module tb_brew_dispense_ctrl;

    localparam int unsigned TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       brew_req = 1'b0;
    logic       enable_timer = 1'b0;
    logic [2:0] coffee_type = '0;
    logic [3:0] change = '0;
`ifdef BREW_ABORT_EN
    logic       abort_req = 1'b0;
    logic [3:0] total_coins = '0;
`endif
    logic       coins_clr, brewing, busy, done;
    logic [4:0] sec_left;

    int n_checks = 0;
    int n_fail = 0;
    int brew_tbl [4] = '{10, 15, 20, 25};

    brew_dispense_ctrl_if coin_bus ();

    always #5 clk = ~clk;

    brew_dispense_ctrl #(
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .brew_req    (brew_req),
        .coffee_type (coffee_type),
        .enable_timer(enable_timer),
        .change      (change),
`ifdef BREW_ABORT_EN
        .abort_req   (abort_req),
        .total_coins (total_coins),
`endif
        .coin        (coin_bus),
        .coins_clr   (coins_clr),
        .brewing     (brewing),
        .busy        (busy),
        .sec_left    (sec_left),
        .done        (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one complete sale and reports what was observed.
    // abort_mode: 0 none, 1 abort when sec_left first reads 7, 2 abort on the final tick.
    task automatic do_sale(input int typ, input int chg, input int tot, input int ready_pct,
                           input int stall_n, input int abort_mode,
                           output int clr_cnt, output int brew_cyc, output int first_sec,
                           output int coins, output int valid_cyc, output int done_cnt,
                           output int sec_err, output int drop_err, output bit timeout);
        int  k = 0;
        int  stalled = 0;
        int  at_one = 0;
        bit  aborted = 0;
        bit  prev_wait = 0;
        clr_cnt = 0; brew_cyc = 0; first_sec = -1; coins = 0; valid_cyc = 0;
        done_cnt = 0; sec_err = 0; drop_err = 0; timeout = 1;
        coffee_type  = 3'(typ);
        change       = 4'(chg);
        enable_timer = 1'b1;
        brew_req     = 1'b1;
`ifdef BREW_ABORT_EN
        total_coins  = 4'(tot);
`endif
        step();
        brew_req     = 1'b0;
        coffee_type  = 3'($urandom_range(0, 7));
        change       = 4'($urandom);
        enable_timer = 1'($urandom);
`ifdef BREW_ABORT_EN
        total_coins  = 4'($urandom);
`endif
        for (int n = 0; n < 1000; n++) begin
`ifdef BREW_ABORT_EN
            abort_req = 1'b0;
`endif
            if (coins_clr) clr_cnt++;
            if (done) begin
                done_cnt++;
                timeout = 0;
                break;
            end
            if (brewing) begin
                if (k == 0) first_sec = int'(sec_left);
                if (sec_left !== 5'(brew_tbl[typ] - k / TICK_DIV)) sec_err++;
                at_one = (sec_left == 5'd1) ? at_one + 1 : 0;
                brew_cyc++;
                k++;
`ifdef BREW_ABORT_EN
                if (!aborted && ((abort_mode == 1 && sec_left == 5'd7) ||
                                 (abort_mode == 2 && at_one == TICK_DIV))) begin
                    abort_req = 1'b1;
                    aborted = 1;
                end
`endif
            end else if (sec_left !== 5'd0) begin
                sec_err++;
            end
            if (prev_wait && !coin_bus.coin_valid) drop_err++;
            if (coin_bus.coin_valid) begin
                valid_cyc++;
                if (stalled < stall_n) begin
                    coin_bus.coin_ready = 1'b0;
                    stalled++;
                end else begin
                    coin_bus.coin_ready = ($urandom_range(1, 100) <= ready_pct);
                end
                if (coin_bus.coin_ready) coins++;
            end else begin
                coin_bus.coin_ready = 1'($urandom);
            end
            prev_wait = coin_bus.coin_valid && !coin_bus.coin_ready;
            step();
        end
        coin_bus.coin_ready = 1'b0;
`ifdef BREW_ABORT_EN
        abort_req = 1'b0;
`endif
        if (aborted == 0 && abort_mode != 0) sec_err++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin
            brew_req            = 1'($urandom);
            enable_timer        = 1'($urandom);
            coffee_type         = 3'($urandom);
            change              = 4'($urandom);
            coin_bus.coin_ready = 1'($urandom);
            step();
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (brewing !== 1'b0) begin n_fail++; $display("FAIL reset_brewing: got %b want 0", brewing); end
        n_checks++; if (coin_bus.coin_valid !== 1'b0) begin n_fail++; $display("FAIL reset_coin_valid: got %b want 0", coin_bus.coin_valid); end
        n_checks++; if (coins_clr !== 1'b0) begin n_fail++; $display("FAIL reset_coins_clr: got %b want 0", coins_clr); end
        n_checks++; if (sec_left !== 5'd0) begin n_fail++; $display("FAIL reset_sec_left: got %0d want 0", sec_left); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        brew_req = 1'b0; enable_timer = 1'b0; coin_bus.coin_ready = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_espresso();
        int c, b, f, co, v, d, se, de; bit to;
        do_sale(0, 2, 0, 100, 0, 0, c, b, f, co, v, d, se, de, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL espresso_timeout: got %b want 0", to); end
        n_checks++; if (c !== 1) begin n_fail++; $display("FAIL espresso_coins_clr: got %0d want 1", c); end
        n_checks++; if (f !== brew_tbl[0]) begin n_fail++; $display("FAIL espresso_first_sec: got %0d want %0d", f, brew_tbl[0]); end
        n_checks++; if (b !== brew_tbl[0] * TICK_DIV) begin n_fail++; $display("FAIL espresso_brew_cycles: got %0d want %0d", b, brew_tbl[0] * TICK_DIV); end
        n_checks++; if (se !== 0) begin n_fail++; $display("FAIL espresso_sec_left_track: got %0d errors want 0", se); end
        n_checks++; if (co !== 2) begin n_fail++; $display("FAIL espresso_coins: got %0d want 2", co); end
        n_checks++; if (v !== 2) begin n_fail++; $display("FAIL espresso_valid_cycles: got %0d want 2", v); end
        n_checks++; if (d !== 1) begin n_fail++; $display("FAIL espresso_done: got %0d want 1", d); end
        step();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL espresso_idle_after: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_mocaccino();
        int c, b, f, co, v, d, se, de; bit to;
        do_sale(3, 0, 0, 100, 0, 0, c, b, f, co, v, d, se, de, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL moca0_timeout: got %b want 0", to); end
        n_checks++; if (b !== brew_tbl[3] * TICK_DIV) begin n_fail++; $display("FAIL moca0_brew_cycles: got %0d want %0d", b, brew_tbl[3] * TICK_DIV); end
        n_checks++; if (v !== 0) begin n_fail++; $display("FAIL moca0_valid_cycles: got %0d want 0", v); end
        n_checks++; if (d !== 1) begin n_fail++; $display("FAIL moca0_done: got %0d want 1", d); end
        step();
        do_sale(3, 3, 0, 100, 5, 0, c, b, f, co, v, d, se, de, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL moca3_timeout: got %b want 0", to); end
        n_checks++; if (co !== 3) begin n_fail++; $display("FAIL moca3_coins: got %0d want 3", co); end
        n_checks++; if (v !== 3 + 5) begin n_fail++; $display("FAIL moca3_valid_cycles: got %0d want 8", v); end
        n_checks++; if (de !== 0) begin n_fail++; $display("FAIL moca3_valid_withdrawn: got %0d want 0", de); end
        n_checks++; if (se !== 0) begin n_fail++; $display("FAIL moca3_sec_left_track: got %0d errors want 0", se); end
        step();
    endtask

    task automatic test_rejections();
        int bcnt = 0;
        int coins = 0;
        bit to = 1;
        brew_req = 1'b1; enable_timer = 1'b0; coffee_type = 3'd1; change = 4'd2;
        step();
        brew_req = 1'b0;
        n_checks++; if (busy !== 1'b0 || coins_clr !== 1'b0) begin n_fail++; $display("FAIL rej_no_enable: got busy=%b clr=%b want 0 0", busy, coins_clr); end
        brew_req = 1'b1; enable_timer = 1'b1; coffee_type = 3'd4;
        step();
        brew_req = 1'b0;
        n_checks++; if (busy !== 1'b0 || coins_clr !== 1'b0) begin n_fail++; $display("FAIL rej_type4: got busy=%b clr=%b want 0 0", busy, coins_clr); end
        brew_req = 1'b1; coffee_type = 3'd0; change = 4'd1;
        step();
        brew_req = 1'b0;
        bcnt += int'(brewing);
        repeat (5) begin
            step();
            bcnt += int'(brewing);
        end
        brew_req = 1'b1; coffee_type = 3'd3; change = 4'd9;
        step();
        brew_req = 1'b0;
        bcnt += int'(brewing);
        n_checks++; if (brewing !== 1'b1 || coins_clr !== 1'b0) begin n_fail++; $display("FAIL rej_in_brew_state: got brewing=%b clr=%b want 1 0", brewing, coins_clr); end
        n_checks++; if (sec_left !== 5'(brew_tbl[0] - 6 / TICK_DIV)) begin n_fail++; $display("FAIL rej_in_brew_sec: got %0d want %0d", sec_left, brew_tbl[0] - 6 / TICK_DIV); end
        for (int n = 0; n < 500; n++) begin
            if (!busy) begin
                to = 0;
                break;
            end
            coin_bus.coin_ready = 1'b1;
            if (coin_bus.coin_valid) coins++;
            step();
            bcnt += int'(brewing);
        end
        coin_bus.coin_ready = 1'b0;
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rej_timeout: got %b want 0", to); end
        n_checks++; if (bcnt !== brew_tbl[0] * TICK_DIV) begin n_fail++; $display("FAIL rej_brew_cycles: got %0d want %0d", bcnt, brew_tbl[0] * TICK_DIV); end
        n_checks++; if (coins !== 1) begin n_fail++; $display("FAIL rej_coins: got %0d want 1", coins); end
    endtask

    task automatic test_reset_mid_sale();
        int paid = 0;
        bit to = 1;
        brew_req = 1'b1; enable_timer = 1'b1; coffee_type = 3'd0; change = 4'd5;
        step();
        brew_req = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (coin_bus.coin_valid && paid == 3) begin
                to = 0;
                break;
            end
            coin_bus.coin_ready = 1'b1;
            if (coin_bus.coin_valid) paid++;
            step();
        end
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL midrst_reach_change: got timeout=%b want 0", to); end
        rst_n = 1'b0;
        step();
        n_checks++; if (busy !== 1'b0 || coin_bus.coin_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_abort: got busy=%b valid=%b want 0 0", busy, coin_bus.coin_valid); end
        rst_n = 1'b1;
        step();
        step();
        n_checks++; if (busy !== 1'b0 || coin_bus.coin_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_coin_owed: got busy=%b valid=%b want 0 0", busy, coin_bus.coin_valid); end
        coin_bus.coin_ready = 1'b0;
    endtask

`ifdef BREW_ABORT_EN
    task automatic test_abort();
        int c, b, f, co, v, d, se, de; bit to;
        do_sale(2, 2, 9, 100, 0, 1, c, b, f, co, v, d, se, de, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL abort7_timeout: got %b want 0", to); end
        n_checks++; if (co !== 9) begin n_fail++; $display("FAIL abort7_refund: got %0d want 9", co); end
        n_checks++; if (b !== (brew_tbl[2] - 7) * TICK_DIV + 1) begin n_fail++; $display("FAIL abort7_brew_cycles: got %0d want %0d", b, (brew_tbl[2] - 7) * TICK_DIV + 1); end
        n_checks++; if (d !== 1) begin n_fail++; $display("FAIL abort7_done: got %0d want 1", d); end
        step();
        do_sale(2, 2, 9, 100, 0, 2, c, b, f, co, v, d, se, de, to);
        n_checks++; if (co !== 9) begin n_fail++; $display("FAIL abort_final_refund: got %0d want 9", co); end
        n_checks++; if (b !== brew_tbl[2] * TICK_DIV) begin n_fail++; $display("FAIL abort_final_brew_cycles: got %0d want %0d", b, brew_tbl[2] * TICK_DIV); end
        step();
        do_sale(1, 4, 0, 100, 0, 1, c, b, f, co, v, d, se, de, to);
        n_checks++; if (v !== 0 || d !== 1) begin n_fail++; $display("FAIL abort_zero_refund: got valid_cycles=%0d done=%0d want 0 1", v, d); end
        step();
    endtask
`endif

    task automatic test_random();
        int c, b, f, co, v, d, se, de; bit to;
        for (int i = 0; i < 8; i++) begin
            int typ = int'($urandom_range(0, 3));
            int chg = int'($urandom_range(0, 15));
            int pct = int'($urandom_range(30, 100));
            do_sale(typ, chg, 0, pct, 0, 0, c, b, f, co, v, d, se, de, to);
            n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout: got %b want 0", i, to); end
            n_checks++; if (b !== brew_tbl[typ] * TICK_DIV) begin n_fail++; $display("FAIL rand%0d_brew_cycles: got %0d want %0d", i, b, brew_tbl[typ] * TICK_DIV); end
            n_checks++; if (f !== brew_tbl[typ]) begin n_fail++; $display("FAIL rand%0d_first_sec: got %0d want %0d", i, f, brew_tbl[typ]); end
            n_checks++; if (co !== chg) begin n_fail++; $display("FAIL rand%0d_coins: got %0d want %0d", i, co, chg); end
            n_checks++; if (c !== 1 || d !== 1) begin n_fail++; $display("FAIL rand%0d_pulses: got clr=%0d done=%0d want 1 1", i, c, d); end
            n_checks++; if (se !== 0 || de !== 0) begin n_fail++; $display("FAIL rand%0d_protocol: got sec_err=%0d drop_err=%0d want 0 0", i, se, de); end
            step();
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_idle_after: got %b want 0", i, busy); end
        end
    endtask

    initial begin
        coin_bus.coin_ready = 1'b0;
        test_reset();
        test_espresso();
        test_mocaccino();
        test_rejections();
        test_reset_mid_sale();
`ifdef BREW_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
